keypad_scanner: RTL and testbench

4x4 matrix-keypad scanner with debounce and a valid/ready key-event output. It runs entirely in the clk domain and advances one column per `scan_tick` enable pulse, which comes from the design's slow-rate timing logic. It drives the keypad columns and samples the pulled-up rows. It emits one 4-bit key code per debounced press to the downstream decoder/display logic.

---
 rtl/keypad_scanner.sv | 182 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix-keypad scanner: column drive, row synchronizer, per-frame press
// classification, press/release debounce and a single-entry valid/ready event register.
module keypad_scanner #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  typedef enum logic [1:0] {S_IDLE, S_DEB_PRESS, S_PRESSED, S_DEB_REL} state_t;

  localparam logic [4:0] DEB = 5'(DEBOUNCE_SCANS);

  logic [3:0]  r_sync [SYNC_STAGES];
  logic [1:0]  r_col_idx;
  logic [15:0] r_bitmap;
  logic        r_frame_done;
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_cand;
  logic [3:0]  r_key_code;
  logic        r_key_valid;
  logic        r_key_held;
  logic        r_overflow;

  logic [3:0]  w_rows;
  logic [15:0] w_col_bits;
  logic [4:0]  w_count;
  logic [3:0]  w_code;
  logic        w_single;
  logic        w_none;
  logic [4:0]  w_cnt_next;
  logic        w_cnt_done;
  logic        w_emit;

  // NOTE: every register in this file uses non-blocking assignment so all flops
  // update from the pre-edge values, whatever order the simulator runs the blocks in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'hF;
    end else begin
      r_sync[0] <= row_n;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_rows = r_sync[SYNC_STAGES-1];
  assign col_n  = ~(4'b0001 << r_col_idx);

  // NOTE: default every combinational output before the loop, otherwise the
  // bits not written on some path become latches.
  always_comb begin
    w_col_bits = '0;
    if (scan_tick) begin
      for (int r = 0; r < 4; r++) w_col_bits[{2'(r), r_col_idx}] = ~w_rows[r];
    end
  end

  // A finished frame is evaluated during the frame_done cycle; a tick landing in
  // that same cycle starts the next frame on a cleared bitmap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col_idx    <= '0;
      r_bitmap     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= scan_tick && (r_col_idx == 2'd3);
      r_bitmap     <= (r_frame_done ? 16'h0000 : r_bitmap) | w_col_bits;
      if (scan_tick) r_col_idx <= r_col_idx + 2'd1;
    end
  end

  always_comb begin
    w_count = '0;
    w_code  = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_bitmap[i]) begin
        w_count = w_count + 5'd1;
        w_code  = 4'(i);
      end
    end
  end

  // Two or more keys in one frame is ghosting and is treated as neither single nor none.
  assign w_single   = (w_count == 5'd1);
  assign w_none     = (w_count == 5'd0);
  assign w_cnt_next = {1'b0, r_cnt} + 5'd1;
  assign w_cnt_done = (w_cnt_next == DEB);
  assign w_emit     = r_frame_done && w_single &&
                      (((r_state == S_IDLE) && (DEBOUNCE_SCANS == 1)) ||
                       ((r_state == S_DEB_PRESS) && (w_code == r_cand) && w_cnt_done));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_key_held  <= 1'b0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (r_frame_done) begin
        case (r_state)
          S_IDLE: if (w_single) begin
            r_cand <= w_code;
            if (DEBOUNCE_SCANS == 1) begin
              r_state    <= S_PRESSED;
              r_key_held <= 1'b1;
            end else begin
              r_state <= S_DEB_PRESS;
              r_cnt   <= 4'd1;
            end
          end
          S_DEB_PRESS: begin
            if (w_single && (w_code == r_cand)) begin
              r_cnt <= w_cnt_next[3:0];
              if (w_cnt_done) begin
                r_state    <= S_PRESSED;
                r_key_held <= 1'b1;
              end
            end else if (w_single) begin
              r_cand <= w_code;
              r_cnt  <= 4'd1;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_PRESSED: if (w_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              r_state    <= S_IDLE;
              r_key_held <= 1'b0;
            end else begin
              r_state <= S_DEB_REL;
              r_cnt   <= 4'd1;
            end
          end
          S_DEB_REL: begin
            if (w_none) begin
              r_cnt <= w_cnt_next[3:0];
              if (w_cnt_done) begin
                r_state    <= S_IDLE;
                r_key_held <= 1'b0;
              end
            end else begin
              r_state <= S_PRESSED;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end

      // A pending event is never overwritten unless it is consumed in the same cycle.
      if (w_emit) begin
        if (!r_key_valid || key_ready) begin
          r_key_code  <= w_code;
          r_key_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_key_valid && key_ready) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a simulated keypad matrix, a frame-history
// reference model compared every cycle, directed scenarios and a randomized phase.
module tb_keypad_scanner;
  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scan_tick = 1'b0;
  logic        key_ready = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        overflow;
  logic [15:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 1;
  int e_cnt = 0;
  int ev_cnt = 0;
  int ov_cnt = 0;
  int rise_edge = -1;
  logic [3:0] last_code = '0;
  bit prev_valid = 0;

  keypad_scanner #(.DEBOUNCE_SCANS(DEB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // A pressed key at (r,c) pulls row r low only while column c is driven low.
  function automatic logic [3:0] keypad_rows(input logic [15:0] keys, input logic [3:0] cols_n);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols_n[c]) rows[r] = 1'b0;
    return rows;
  endfunction

  always_comb row_n = keypad_rows(pressed, col_n);

  // ---------------- reference model ----------------
  int         m_col;
  logic [15:0] m_keys;
  bit         m_pending;
  logic [3:0] m_hist[$];
  int         m_frames[$];
  bit         m_held;
  logic       exp_valid, exp_overflow, exp_held;
  logic [3:0] exp_code;

  function automatic logic [3:0] col_drive(input int c);
    logic [3:0] v;
    v = 4'hF;
    v[c] = 1'b0;
    return v;
  endfunction

  // Frame result: key index for exactly one key, -1 for none, -2 for several.
  function automatic int classify(input logic [15:0] keys);
    int n, idx;
    n = 0;
    idx = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) begin n++; idx = i; end
    if (n == 0) return -1;
    if (n == 1) return idx;
    return -2;
  endfunction

  function automatic bit last_frames_all(input int v);
    if (m_frames.size() < DEB) return 0;
    foreach (m_frames[i]) if (m_frames[i] != v) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_col = 0;
    m_keys = '0;
    m_pending = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(4'hF);
    m_frames.delete();
    m_held = 0;
    exp_valid = 0;
    exp_overflow = 0;
    exp_held = 0;
    exp_code = '0;
  endtask

  task automatic model_step();
    logic [3:0] synced;
    int res;
    bit emit;
    if (!rst) begin
      model_reset();
      return;
    end
    synced = m_hist.pop_front();
    m_hist.push_back(keypad_rows(pressed, col_drive(m_col)));
    emit = 0;
    res = -1;
    exp_overflow = 0;
    if (m_pending) begin
      res = classify(m_keys);
      m_keys = '0;
      m_pending = 0;
      m_frames.push_back(res);
      if (m_frames.size() > DEB) void'(m_frames.pop_front());
      if (!m_held && res >= 0 && last_frames_all(res)) begin
        emit = 1;
        m_held = 1;
      end else if (m_held && last_frames_all(-1)) begin
        m_held = 0;
      end
    end
    if (scan_tick) begin
      for (int r = 0; r < 4; r++) if (!synced[r]) m_keys[r*4+m_col] = 1'b1;
      if (m_col == 3) m_pending = 1;
      m_col = (m_col + 1) % 4;
    end
    if (emit) begin
      if (!exp_valid || key_ready) begin
        exp_code = 4'(res);
        exp_valid = 1;
      end else begin
        exp_overflow = 1;
      end
    end else if (exp_valid && key_ready) begin
      exp_valid = 0;
    end
    exp_held = m_held;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    e_cnt++;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("col_n", 16'(col_n), 16'(col_drive(m_col)));
      check("key_valid", 16'(key_valid), 16'(exp_valid));
      check("key_held", 16'(key_held), 16'(exp_held));
      check("overflow", 16'(overflow), 16'(exp_overflow));
      if (exp_valid) check("key_code", 16'(key_code), 16'(exp_code));
    end
  end

  initial forever begin
    @(negedge clk);
    if (key_valid === 1'b1 && key_ready) begin
      ev_cnt++;
      last_code = key_code;
    end
    if (overflow === 1'b1) ov_cnt++;
    if (key_valid === 1'b1 && !prev_valid) rise_edge = e_cnt;
    prev_valid = (key_valid === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic tick);
    scan_tick = tick;
    case (ready_mode)
      0: key_ready = 1'b0;
      1: key_ready = 1'b1;
      default: key_ready = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    #1;
  endtask

  // Each tick lands on the last of four cycles so rows have settled for the column.
  task automatic frames(input int n);
    for (int f = 0; f < n * 4; f++) begin
      step(1'b0);
      step(1'b0);
      step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic do_reset(input int n, input bit random_keys);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (random_keys) pressed = 16'($urandom);
      step(1'($urandom_range(0, 1)));
    end
  endtask

  int ev0, ov0, t_edge;

  initial begin
    // Reset with random keys and ticks.
    do_reset(4, 1);
    check("rst col_n", 16'(col_n), 16'hE);
    check("rst key_valid", 16'(key_valid), 16'h0);
    check("rst key_held", 16'(key_held), 16'h0);
    check("rst overflow", 16'(overflow), 16'h0);
    pressed = '0;
    rst = 1'b1;
    step(1'b1); check("col step 1", 16'(col_n), 16'hD);
    step(1'b1); check("col step 2", 16'(col_n), 16'hB);
    step(1'b1); check("col step 3", 16'(col_n), 16'h7);
    step(1'b1); check("col step 0", 16'(col_n), 16'hE);

    // Clean press of row1/col2.
    ev0 = ev_cnt;
    pressed = 16'(1) << 6;
    frames(4);
    t_edge = e_cnt;
    frames(2);
    check("clean event count", 16'(ev_cnt - ev0), 16'd1);
    check("clean code", 16'(last_code), 16'd6);
    check("clean latency", 16'(rise_edge - t_edge), 16'd1);
    check("clean held", 16'(key_held), 16'd1);
    pressed = '0;
    frames(5);
    check("clean released", 16'(key_held), 16'd0);
    check("clean single event", 16'(ev_cnt - ev0), 16'd1);

    // Bounce on row0/col1.
    ev0 = ev_cnt;
    pressed = 16'(1) << 1;
    frames(2);
    pressed = '0;
    frames(1);
    pressed = 16'(1) << 1;
    frames(3);
    step(1'b0); step(1'b0);
    check("bounce early", 16'(ev_cnt - ev0), 16'd0);
    frames(1);
    step(1'b0); step(1'b0);
    check("bounce event", 16'(ev_cnt - ev0), 16'd1);
    check("bounce code", 16'(last_code), 16'd1);
    pressed = '0;
    frames(5);

    // Ghosting: two keys together.
    ev0 = ev_cnt;
    pressed = (16'(1) << 0) | (16'(1) << 11);
    frames(8);
    check("ghost no event", 16'(ev_cnt - ev0), 16'd0);
    check("ghost held", 16'(key_held), 16'd0);
    pressed = '0;
    frames(1);

    // Backpressure: second event dropped while the first is pending.
    ready_mode = 0;
    ov0 = ov_cnt;
    pressed = 16'(1) << 5;
    frames(5);
    pressed = '0;
    frames(5);
    pressed = 16'(1) << 9;
    frames(5);
    step(1'b0); step(1'b0);
    check("bp valid held", 16'(key_valid), 16'd1);
    check("bp code kept", 16'(key_code), 16'd5);
    check("bp overflow pulses", 16'(ov_cnt - ov0), 16'd1);
    ready_mode = 1;
    step(1'b0);
    ready_mode = 0;
    check("bp consumed", 16'(key_valid), 16'd0);
    pressed = '0;
    frames(5);
    ready_mode = 1;

    // Reset in the middle of debouncing code 15.
    ev0 = ev_cnt;
    pressed = 16'(1) << 15;
    frames(2);
    do_reset(3, 0);
    check("mid rst col_n", 16'(col_n), 16'hE);
    rst = 1'b1;
    frames(3);
    step(1'b0); step(1'b0);
    check("mid rst no early event", 16'(ev_cnt - ev0), 16'd0);
    frames(1);
    step(1'b0); step(1'b0);
    check("mid rst event", 16'(ev_cnt - ev0), 16'd1);
    check("mid rst code", 16'(last_code), 16'd15);
    pressed = '0;
    frames(5);

    // Randomized phase: random keys, tick rates and backpressure.
    ready_mode = 2;
    begin
      int rate;
      int k;
      rate = 3;
      for (int i = 0; i < 3000; i++) begin
        if (i % 500 == 0) rate = $urandom_range(0, 4);
        if ($urandom_range(0, 150) == 0) begin
          k = $urandom_range(0, 3);
          if (k == 0) pressed = '0;
          else if (k == 3) pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
          else pressed = 16'(1) << $urandom_range(0, 15);
        end
        if (i == 1500) begin
          do_reset(2, 0);
          rst = 1'b1;
        end
        step(1'($urandom_range(0, rate) == 0));
      end
    end
    pressed = '0;
    ready_mode = 1;
    frames(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
